fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl.sv | 110 +++++++++++
 tb/tb_fifo_wr_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: synchronises the read pointer,
// advances the binary/Gray write pointer and produces full, occupancy and overflow flags.
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray,
  input  logic                  clr_ovf,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  typedef logic [PW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t rq1_r, rq2_r, wbin_r, gray_r, cnt_r;
  logic full_r, af_r, ovf_r;

  logic accept_s, full_next_s, af_next_s;
  ptr_t rbin_s, wbin_next_s, gray_next_s, cnt_next_s;

  // Next-state arithmetic; accept is gated by reset so mem_we stays low while held in reset
  always_comb begin
    accept_s    = 1'b0;
    rbin_s      = gray2bin(rq2_r);
    wbin_next_s = wbin_r;
    if (rst_n && wr_en && !full_r) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
    wbin_next_s = wbin_r + {{ADDR_WIDTH{1'b0}}, accept_s};
    gray_next_s = bin2gray(wbin_next_s);
    cnt_next_s  = wbin_next_s - rbin_s;
    // Full when the write pointer leads the read pointer by exactly one lap.
    full_next_s = (gray_next_s == {~rq2_r[PW-1:PW-2], rq2_r[PW-3:0]});
    af_next_s   = (cnt_next_s >= PW'(AFULL_THRESH));
  end

  // Two-flop synchroniser for the read-domain Gray pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rq1_r <= {PW{1'b0}};
      rq2_r <= {PW{1'b0}};
    end else begin
      rq1_r <= rd_ptr_gray;
      rq2_r <= rq1_r;
    end
  end

  // Write pointer and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_r <= {PW{1'b0}};
      gray_r <= {PW{1'b0}};
      cnt_r  <= {PW{1'b0}};
      full_r <= 1'b0;
      af_r   <= 1'b0;
    end else begin
      wbin_r <= wbin_next_s;
      gray_r <= gray_next_s;
      cnt_r  <= cnt_next_s;
      full_r <= full_next_s;
      af_r   <= af_next_s;
    end
  end

  // Sticky overflow; a new overflow outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (wr_en && full_r) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign mem_we      = accept_s;
  assign wr_addr     = wbin_r[ADDR_WIDTH-1:0];
  assign wr_ptr_gray = gray_r;
  assign full        = full_r;
  assign almost_full = af_r;
  assign wr_count    = cnt_r;
  assign overflow    = ovf_r;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: an occupancy-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [4:0] rd_bin = 5'd0;
  logic [4:0] rd_ptr_gray;
  logic       mem_we;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full, almost_full, overflow;
  logic [4:0] wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  assign rd_ptr_gray = rd_bin ^ (rd_bin >> 1);

  fifo_wr_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_ptr_gray(rd_ptr_gray),
    .clr_ovf(clr_ovf), .mem_we(mem_we), .wr_addr(wr_addr),
    .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
    .wr_count(wr_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes counted as an integer, read pointer seen two edges late
  int wptr = 0, rd_d1 = 0, rd_d2 = 0, rd_use = 0, cnt_m = 0;
  bit full_m = 0, af_m = 0, ovf_m = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr = 0; rd_d1 = 0; rd_d2 = 0; cnt_m = 0;
      full_m = 0; af_m = 0; ovf_m = 0;
    end else begin
      if (wr_en && full_m) ovf_m = 1;
      else if (clr_ovf) ovf_m = 0;
      if (wr_en && !full_m) wptr = (wptr + 1) % 32;
      rd_use = rd_d2;
      rd_d2  = rd_d1;
      rd_d1  = int'(rd_bin);
      cnt_m  = (wptr - rd_use + 32) % 32;
      full_m = (cnt_m == 16);
      af_m   = (cnt_m >= 12);
    end
  end

  // Per-cycle comparison against the model, plus the one-bit Gray step check
  logic [4:0] prev_gray = 5'd0;
  always @(negedge clk) begin
    chk("mem_we", int'(mem_we), int'(rst_n && wr_en && !full_m));
    chk("wr_addr", int'(wr_addr), wptr % 16);
    chk("wr_ptr_gray", int'(wr_ptr_gray), wptr ^ (wptr >> 1));
    chk("full", int'(full), int'(full_m));
    chk("almost_full", int'(almost_full), int'(af_m));
    chk("wr_count", int'(wr_count), cnt_m);
    chk("overflow", int'(overflow), int'(ovf_m));
    if (rst_n) chk("gray_onebit", int'($countones(wr_ptr_gray ^ prev_gray) <= 1), 1);
    prev_gray = wr_ptr_gray;
  end

  task automatic step(input bit w, input bit c);
    wr_en   = w;
    clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(wr_count), 0);
    chk("rst_gray", int'(wr_ptr_gray), 0);
    rst_n = 1'b1;

    // Fill from empty with the read pointer parked at 0
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      #0 chk("fill_addr", int'(wr_addr), i);
      step(1'b1, 1'b0);
      if (i == 10) chk("af_after11", int'(almost_full), 0);
      if (i == 11) chk("af_after12", int'(almost_full), 1);
    end
    chk("full_after16", int'(full), 1);
    chk("count_after16", int'(wr_count), 16);
    chk("gray_after16", int'(wr_ptr_gray), 5'b11000);

    // Write while full is dropped and flags overflow
    wr_en = 1'b1;
    #1 chk("drop_we", int'(mem_we), 0);
    chk("drop_addr", int'(wr_addr), 0);
    step(1'b1, 1'b0);
    chk("ovf_set", int'(overflow), 1);
    chk("drop_gray", int'(wr_ptr_gray), 5'b11000);
    step(1'b0, 1'b1);
    chk("ovf_clr", int'(overflow), 0);
    step(1'b1, 1'b1);
    chk("ovf_set_wins", int'(overflow), 1);
    step(1'b0, 1'b1);
    chk("ovf_clr2", int'(overflow), 0);

    // One read: visible on the third edge only
    rd_bin = 5'd1;
    step(1'b0, 1'b0);
    chk("rd_edge1_full", int'(full), 1);
    step(1'b0, 1'b0);
    chk("rd_edge2_full", int'(full), 1);
    step(1'b0, 1'b0);
    chk("rd_edge3_full", int'(full), 0);
    chk("rd_edge3_count", int'(wr_count), 15);

    // Fresh start for the almost-full threshold
    rst_n = 1'b0;
    rd_bin = 5'd0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    chk("af12_count", int'(wr_count), 12);
    chk("af12", int'(almost_full), 1);
    rd_bin = 5'd1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("af_hold_edge2", int'(almost_full), 1);
    step(1'b0, 1'b0);
    chk("af_drop_edge3", int'(almost_full), 0);
    chk("af_drop_count", int'(wr_count), 11);

    // Stream across the pointer wrap with the reader trailing
    for (int i = 0; i < 19; i++) begin
      rd_bin = rd_bin + 5'd1;
      step(1'b1, 1'b0);
    end
    chk("wrap_gray31", int'(wr_ptr_gray), 5'b10000);
    chk("wrap_addr15", int'(wr_addr), 15);
    rd_bin = rd_bin + 5'd1;
    step(1'b1, 1'b0);
    chk("wrap_gray0", int'(wr_ptr_gray), 5'b00000);
    chk("wrap_addr0", int'(wr_addr), 0);
    for (int i = 0; i < 5; i++) begin
      rd_bin = rd_bin + 5'd1;
      step(1'b1, 1'b0);
    end

    // Asynchronous reset in the middle of a burst
    wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", int'(mem_we), 0);
    chk("arst_addr", int'(wr_addr), 0);
    chk("arst_gray", int'(wr_ptr_gray), 0);
    chk("arst_count", int'(wr_count), 0);
    chk("arst_af", int'(almost_full), 0);
    rd_bin = 5'd0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("post_rst_we", int'(mem_we), 1);
    chk("post_rst_addr", int'(wr_addr), 0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("post_rst_count", int'(wr_count), 2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
